clm_sbox_sched: RTL and testbench
=================================

// Module: clm_sbox_sched
// PURPOSE
//  Sequences one shared CLM S-box over a full cipher state of NBYTES masked bytes.
//  Per byte: fetch fresh masking randomness, issue the byte to the S-box, wait for its
//  drdy_o, write the result back in place. Sits between round control and the S-box.
//  One S-box serves all bytes; byte processing is strictly serial.
// PARAMETERS
//  D        4    redundancy bits; masked word width W = 8+D (state_t width)
//  NBYTES   16   bytes per state
//  NRND     7    random words per S-box evaluation (r[0..6])
//  TIMEOUT  15   max WAIT cycles before err_o
// PORTS
//  clk           in   1          clock
//  rst           in   1          synchronous, active-high reset; also drives S-box rst
//  start_i       in   1          start pulse; sampled only in IDLE
//  state_i       in   NBYTES*W   input state; byte k = [k*W +: W]
//  state_o       out  NBYTES*W   result buffer, same packing
//  busy_o        out  1          high from the cycle after start until DONE/err
//  done_o        out  1          one-cycle pulse; state_o valid
//  err_o         out  1          sticky S-box timeout flag; cleared by next accepted start
//  rnd_i         in   NRND*W     randomness words; word j = [j*W +: W]
//  rnd_valid_i   in   1          rnd_i valid
//  rnd_ready_o   out  1          scheduler accepts rnd_i (transfer = valid & ready)
//  sbox_in_o     out  W          byte to S-box
//  sbox_r_o      out  NRND*W     latched randomness to S-box
//  sbox_drdy_o   out  1          S-box drdy_i strobe
//  sbox_drdy_i   in   1          S-box drdy_o
//  sbox_out_i    in   W          S-box result, valid while sbox_drdy_i
// BEHAVIOUR
//  Reset: FSM=IDLE, idx=0, wait_ctr=0, buffer/rnd regs=0; all outputs 0.
//  FSM states and transitions:
//   IDLE : start_i -> load buffer<=state_i, idx<=0, err_o<=0 -> FETCH. busy_o=0.
//   FETCH: rnd_ready_o=1. On valid&ready: rnd_reg<=rnd_i -> ISSUE. Stalls indefinitely.
//   ISSUE: sbox_drdy_o=1 for exactly this cycle; wait_ctr<=0 -> WAIT.
//   WAIT : on sbox_drdy_i: buffer[idx]<=sbox_out_i; idx==NBYTES-1 -> DONE, else
//          idx<=idx+1 -> FETCH. Otherwise wait_ctr++; wait_ctr==TIMEOUT-1 ->
//          err_o<=1 -> IDLE, no done_o, buffer keeps partial results.
//          sbox_drdy_i and timeout in the same cycle: sbox_drdy_i wins.
//   DONE : done_o=1 one cycle -> IDLE.
//  sbox_in_o = buffer[idx], sbox_r_o = rnd_reg; both held constant from ISSUE through
//   the cycle sbox_drdy_i is seen (S-box reads r in every stage). rnd_reg updates
//   only in FETCH.
//  state_o = buffer continuously; stable in IDLE until next accepted start.
//  start_i while busy (any non-IDLE state) is ignored; no queuing.
//  Latency (rnd_valid_i held high, 7-cycle S-box): FETCH 1 + ISSUE 1 + WAIT 6 = 8 cycles
//   per byte; done_o high 129 cycles after the start edge for NBYTES=16.
//  Each rnd_i stall cycle adds exactly 1 cycle.
//  Reset mid-operation: immediate return to IDLE, all regs cleared, no done_o;
//   the S-box is reset by the same rst.
//  idx width = $clog2(NBYTES); never wraps (terminates at NBYTES-1).
// TESTING
//  T1 reset: assert rst 2 cycles -> busy/done/err/rnd_ready/sbox_drdy_o all 0, state_o=0.
//  T2 full run, stub S-box (out=in+1 after 6 cycles), state_i bytes 0..15, rnd valid
//     always -> done_o at cycle 129, state_o bytes 1..16, 16 sbox_drdy_o pulses.
//  T3 drop rnd_valid_i 3 cycles before byte 5 -> done_o at cycle 132; sbox_r_o
//     constant during every ISSUE..drdy window.
//  T4 start_i pulsed at cycle 40 of a run -> ignored, result and timing as in T2.
//  T5 stub never asserts drdy -> err_o=1 after TIMEOUT WAIT cycles, FSM IDLE, no done_o;
//     next start clears err_o.
//  T6 rst at cycle 60, then new start -> clean run, results as in T2.

Source files
------------

// File: rtl/clm_sbox_sched.sv
// Serial scheduler that feeds a shared masked CLM S-box one state byte at a time.
// Each byte: fetch fresh randomness, issue to the S-box, wait for the result, write it back.
module clm_sbox_sched #(
  parameter int unsigned D       = 4,
  parameter int unsigned NBYTES  = 16,
  parameter int unsigned NRND    = 7,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned W      = 8 + D,
  localparam int unsigned IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1,
  localparam int unsigned CtrW   = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [NBYTES*W-1:0]  state_i,
  output logic [NBYTES*W-1:0]  state_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic [NRND*W-1:0]    rnd_i,
  input  logic                 rnd_valid_i,
  output logic                 rnd_ready_o,
  output logic [W-1:0]         sbox_in_o,
  output logic [NRND*W-1:0]    sbox_r_o,
  output logic                 sbox_drdy_o,
  input  logic                 sbox_drdy_i,
  input  logic [W-1:0]         sbox_out_i
);

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StDone} st_e;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);
  localparam logic [CtrW-1:0] LastCtr = CtrW'(TIMEOUT - 1);

  st_e                  st_q, st_d;
  logic [NBYTES*W-1:0]  state_buf_q, state_buf_d;
  logic [NRND*W-1:0]    rnd_q, rnd_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [CtrW-1:0]      wait_ctr_q, wait_ctr_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:  if (start_i) st_d = StFetch;
      StFetch: if (rnd_valid_i) st_d = StIssue;
      StIssue: st_d = StWait;
      StWait: begin
        // A result arriving on the last allowed cycle beats the timeout.
        if (sbox_drdy_i) begin
          st_d = (idx_q == LastIdx) ? StDone : StFetch;
        end else if (wait_ctr_q == LastCtr) begin
          st_d = StIdle;
        end
      end
      StDone:  st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_comb begin
    state_buf_d = state_buf_q;
    rnd_d       = rnd_q;
    idx_d       = idx_q;
    wait_ctr_d  = wait_ctr_q;
    err_d       = err_q;
    unique case (st_q)
      StIdle: begin
        if (start_i) begin
          state_buf_d = state_i;
          idx_d       = '0;
          err_d       = 1'b0;
        end
      end
      StFetch: if (rnd_valid_i) rnd_d = rnd_i;
      StIssue: wait_ctr_d = '0;
      StWait: begin
        if (sbox_drdy_i) begin
          state_buf_d[idx_q*W +: W] = sbox_out_i;
          if (idx_q != LastIdx) idx_d = idx_q + IdxW'(1);
        end else begin
          wait_ctr_d = wait_ctr_q + CtrW'(1);
          if (wait_ctr_q == LastCtr) err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_buf_q <= '0;
      rnd_q       <= '0;
      idx_q       <= '0;
      wait_ctr_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_buf_q <= state_buf_d;
      rnd_q       <= rnd_d;
      idx_q       <= idx_d;
      wait_ctr_q  <= wait_ctr_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    rnd_ready_o = 1'b0;
    sbox_drdy_o = 1'b0;
    unique case (st_q)
      StIdle:  ;
      StFetch: begin busy_o = 1'b1; rnd_ready_o = 1'b1; end
      StIssue: begin busy_o = 1'b1; sbox_drdy_o = 1'b1; end
      StWait:  busy_o = 1'b1;
      StDone:  begin busy_o = 1'b1; done_o = 1'b1; end
      default: ;
    endcase
  end

  // S-box reads its inputs at every stage, so both stay put until the result returns.
  assign sbox_in_o = state_buf_q[idx_q*W +: W];
  assign sbox_r_o  = rnd_q;
  assign state_o   = state_buf_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_clm_sbox_sched.sv
// Bench for clm_sbox_sched: stub S-box (result = input + 1, six WAIT cycles) and a
// randomness source with a programmable stall; results checked against an arithmetic model.
module tb_clm_sbox_sched;
  localparam int NBYTES = 16, NRND = 7, TIMEOUT = 15, W = 12;
  localparam int SW = NBYTES * W, RW = NRND * W;

  logic          clk = 1'b0, rst = 1'b1, start_i = 1'b0;
  logic [SW-1:0] state_i = '0, state_o;
  logic          busy_o, done_o, err_o, rnd_ready_o, sbox_drdy_o;
  logic [RW-1:0] rnd_i = '0, sbox_r_o;
  logic          rnd_valid_i = 1'b1, sbox_drdy_i = 1'b0;
  logic [W-1:0]  sbox_in_o, sbox_out_i = '0;

  clm_sbox_sched dut (
    .clk(clk), .rst(rst), .start_i(start_i), .state_i(state_i), .state_o(state_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rnd_i(rnd_i),
    .rnd_valid_i(rnd_valid_i), .rnd_ready_o(rnd_ready_o), .sbox_in_o(sbox_in_o),
    .sbox_r_o(sbox_r_o), .sbox_drdy_o(sbox_drdy_o), .sbox_drdy_i(sbox_drdy_i),
    .sbox_out_i(sbox_out_i)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int stall_byte = -1, stall_len = 0;
  bit stub_dead = 1'b0;

  int stall_left = 0, xfer_cnt = 0, issue_cnt = 0, hold_viol = 0, wcnt = 0;
  bit pending = 1'b0;
  logic [W-1:0]  cap_in = '0;
  logic [RW-1:0] cap_r = '0, last_rnd = '0;

  function automatic logic [RW-1:0] rand_rnd();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[RW-1:0];
  endfunction

  // Environment: randomness source and S-box stub, acting between clock edges.
  always @(negedge clk) begin
    if (rst) begin
      wcnt = 0; sbox_drdy_i = 1'b0; pending = 1'b0;
    end else begin
      if (start_i && !busy_o) begin
        xfer_cnt = 0; issue_cnt = 0; hold_viol = 0; stall_left = stall_len; wcnt = 0;
      end
      if (pending) begin xfer_cnt++; rnd_i = rand_rnd(); pending = 1'b0; end
      if (sbox_drdy_i) sbox_drdy_i = 1'b0;
      if (sbox_drdy_o) begin
        issue_cnt++;
        if (!stub_dead) begin
          wcnt = 1; cap_in = sbox_in_o; cap_r = sbox_r_o;
          if (cap_r !== last_rnd) hold_viol++;
        end
      end else if (wcnt != 0) begin
        if (sbox_in_o !== cap_in || sbox_r_o !== cap_r) hold_viol++;
        if (wcnt == 6) begin
          sbox_drdy_i = 1'b1; sbox_out_i = cap_in + W'(1); wcnt = 0;
        end else wcnt++;
      end
      if (rnd_ready_o && xfer_cnt == stall_byte && stall_left != 0) begin
        rnd_valid_i = 1'b0; stall_left--;
      end else rnd_valid_i = 1'b1;
      if (rnd_ready_o && rnd_valid_i) begin pending = 1'b1; last_rnd = rnd_i; end
    end
  end

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] s;
    for (int k = 0; k < NBYTES; k++) s[k*W +: W] = W'($urandom);
    return s;
  endfunction

  // Full operation; the expected result and done cycle come from the byte-level model.
  task automatic run(input string tag, input logic [SW-1:0] st, input int sb, input int sn,
                     input int restart_at);
    int cyc, exp_cyc;
    logic [SW-1:0] exp_st;
    stall_byte = sb; stall_len = sn; state_i = st;
    for (int k = 0; k < NBYTES; k++) exp_st[k*W +: W] = st[k*W +: W] + W'(1);
    exp_cyc = 1 + NBYTES * (1 + 1 + 6) + ((sb >= 0 && sb < NBYTES) ? sn : 0);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; cyc = 1;
    chk({tag, ":busy_at_start"}, SW'(busy_o), SW'(1));
    chk({tag, ":err_cleared"}, SW'(err_o), SW'(0));
    while (!done_o && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      start_i = (cyc == restart_at);
    end
    start_i = 1'b0;
    chk({tag, ":done_cycle"}, SW'(cyc), SW'(exp_cyc));
    chk({tag, ":result"}, state_o, exp_st);
    chk({tag, ":issue_pulses"}, SW'(issue_cnt), SW'(NBYTES));
    chk({tag, ":sbox_inputs_held"}, SW'(hold_viol), SW'(0));
    @(posedge clk); #1;
    chk({tag, ":done_one_cycle"}, SW'({done_o, busy_o}), SW'(0));
    chk({tag, ":result_stable"}, state_o, exp_st);
  endtask

  initial begin
    logic [SW-1:0] st;
    int cyc;
    bit saw_done;

    // T1 reset
    repeat (2) @(posedge clk);
    #1;
    chk("T1:ctrl_outs", SW'({busy_o, done_o, err_o, rnd_ready_o, sbox_drdy_o}), SW'(0));
    chk("T1:state_o", state_o, '0);
    chk("T1:sbox_outs", SW'({sbox_in_o, sbox_r_o}), '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("T1:idle_after_rst", SW'({busy_o, done_o, err_o, rnd_ready_o}), SW'(0));

    // T2 byte k = k
    for (int k = 0; k < NBYTES; k++) st[k*W +: W] = W'(k);
    run("T2", st, -1, 0, -1);

    // T3 three-cycle randomness stall before byte 5, one byte wraps
    st = rand_state();
    st[7*W +: W] = '1;
    run("T3", st, 5, 3, -1);

    // T4 start while busy is ignored
    run("T4", rand_state(), -1, 0, 40);

    // T5 S-box never answers
    stub_dead = 1'b1;
    st = rand_state();
    state_i = st;
    saw_done = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; cyc = 1;
    while (!err_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done_o) saw_done = 1'b1;
    end
    chk("T5:err_cycle", SW'(cyc), SW'(3 + TIMEOUT));
    chk("T5:idle_no_done", SW'({busy_o, done_o, saw_done, rnd_ready_o}), SW'(0));
    chk("T5:buffer_kept", state_o, st);
    repeat (3) @(posedge clk);
    #1;
    chk("T5:err_sticky", SW'(err_o), SW'(1));
    stub_dead = 1'b0;
    run("T5b", rand_state(), 0, 2, -1);

    // T6 reset mid-run, then a clean run
    state_i = rand_state();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; cyc = 1;
    while (cyc < 60) begin @(posedge clk); #1; cyc++; end
    chk("T6:busy_mid_run", SW'(busy_o), SW'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("T6:ctrl_after_rst", SW'({busy_o, done_o, err_o, rnd_ready_o, sbox_drdy_o}), SW'(0));
    chk("T6:state_after_rst", state_o, '0);
    for (int k = 0; k < NBYTES; k++) st[k*W +: W] = W'(k);
    run("T6b", st, -1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
